// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU and the iterative multiply/divide unit.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_MFHI = 4'd9;
  localparam logic [3:0] ALU_MFLO = 4'd10;
  localparam logic [3:0] ALU_NOR  = 4'd12;
  localparam logic [3:0] ALU_XOR  = 4'd13;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide on operand magnitudes with HI/LO result registers.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  localparam int unsigned CW = $clog2(W + 1);

  mdu_state_e     state_q, state_d;
  logic           load, step, finish;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     op_q;
  logic [W-1:0]   a_q, b_q, acc_q, q_q;
  logic           sgn_in, sgn_q, is_div, sa, sb;
  logic [W-1:0]   mag_b;
  logic [W:0]     add_sum, shifted, trial;
  logic [W-1:0]   acc_d, q_d;
  logic [2*W-1:0] prod;
  logic [W-1:0]   res_hi, res_lo;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? -x : x;
  endfunction

  assign sgn_in = (op == MD_MULT) || (op == MD_DIV);
  assign sgn_q  = (op_q == MD_MULT) || (op_q == MD_DIV);
  assign is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign sa     = sgn_q & a_q[W-1];
  assign sb     = sgn_q & b_q[W-1];
  assign mag_b  = mag(b_q, sgn_q);

  // One step: shift-add for multiply, restoring trial subtract for divide
  always_comb begin
    acc_d   = acc_q;
    q_d     = q_q;
    add_sum = {1'b0, acc_q} + {1'b0, mag_b};
    shifted = {acc_q, q_q[W-1]};
    trial   = shifted - {1'b0, mag_b};
    if (is_div) begin
      if (trial[W]) begin
        acc_d = shifted[W-1:0];
        q_d   = {q_q[W-2:0], 1'b0};
      end else begin
        acc_d = trial[W-1:0];
        q_d   = {q_q[W-2:0], 1'b1};
      end
    end else if (q_q[0]) begin
      {acc_d, q_d} = {add_sum, q_q[W-1:1]};
    end else begin
      {acc_d, q_d} = {1'b0, acc_q, q_q[W-1:1]};
    end
  end

  // Sign fix-up of the final step; divide-by-zero returns all ones / dividend
  always_comb begin
    prod = {acc_d, q_d};
    if (sa ^ sb) prod = -prod;
    res_hi = prod[2*W-1:W];
    res_lo = prod[W-1:0];
    if (is_div) begin
      res_lo = (sa ^ sb) ? -q_d : q_d;
      res_hi = sa ? -acc_d : acc_d;
      if (b_q == '0) begin
        res_lo = '1;
        res_hi = a_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MDU_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = MDU_RUN;
        end
      end
      MDU_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt_q == CW'(1)) begin
          finish  = 1'b1;
          state_d = MDU_DONE;
        end
      end
      MDU_DONE: begin
        done = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = MDU_RUN;
        end else begin
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      q_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (load) begin
        cnt_q <= CW'(W);
        op_q  <= op;
        a_q   <= a;
        b_q   <= b;
        acc_q <= '0;
        q_q   <= mag(a, sgn_in);
      end else if (step) begin
        cnt_q <= cnt_q - CW'(1);
        acc_q <= acc_d;
        q_q   <= q_d;
      end
      if (finish) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU: single-cycle combinational ops plus an iterative MDU with HI/LO.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned W = 32,
  localparam int unsigned SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    ctl,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [SW-1:0] shamt,
  output logic [W-1:0]  out,
  output logic          zero,
  output logic          overflow,
  input  logic          md_start,
  input  logic [1:0]    md_op,
  output logic          md_busy,
  output logic          md_done,
  output logic [W-1:0]  hi,
  output logic [W-1:0]  lo
);
  logic [W-1:0] sum, diff;
  logic [W:0]   diff_ext;
  logic         ovf_add, ovf_sub;

  assign sum      = a + b;
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign diff     = diff_ext[W-1:0];
  assign ovf_add  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
  assign ovf_sub  = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);

  // slt uses sign xor overflow so it stays correct when the subtract wraps
  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (ctl)
      ALU_AND:  out = a & b;
      ALU_OR:   out = a | b;
      ALU_ADD:  begin out = sum;  overflow = ovf_add; end
      ALU_SLTU: out = W'(diff_ext[W]);
      ALU_SLL:  out = b << shamt;
      ALU_SRL:  out = b >> shamt;
      ALU_SUB:  begin out = diff; overflow = ovf_sub; end
      ALU_SLT:  out = W'(diff[W-1] ^ ovf_sub);
      ALU_SRA:  out = W'($signed(b) >>> shamt);
      ALU_MFHI: out = hi;
      ALU_MFLO: out = lo;
      ALU_NOR:  out = ~(a | b);
      ALU_XOR:  out = a ^ b;
      default:  out = '0;
    endcase
  end

  assign zero = (out == '0);

  mdu_iter #(.W(W)) u_mdu (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (md_op),
    .a     (a),
    .b     (b),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: random and directed ALU/MDU traffic against a behavioural model.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned SW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    ctl = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic [SW-1:0] shamt = '0;
  logic [W-1:0]  out;
  logic          zero, overflow;
  logic          md_start = 1'b0;
  logic [1:0]    md_op = '0;
  logic          md_busy, md_done;
  logic [W-1:0]  hi, lo;

  alu_mdu #(.W(W)) dut (
    .clk(clk), .rst(rst), .ctl(ctl), .a(a), .b(b), .shamt(shamt),
    .out(out), .zero(zero), .overflow(overflow),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_done(md_done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [W-1:0] out; logic zero; logic ovf;} alu_exp_t;
  typedef struct packed {logic [W-1:0] hi; logic [W-1:0] lo;} md_exp_t;

  alu_exp_t     alu_q[$];
  md_exp_t      md_q[$];
  logic         alu_vld = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int           n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic alu_exp_t alu_ref(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic [SW-1:0] sh, input logic [W-1:0] h, input logic [W-1:0] l);
    alu_exp_t e;
    longint sx, sy, r, lim;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    lim = longint'(1) << (W - 1);
    e.out = '0;
    e.ovf = 1'b0;
    case (c)
      4'd0:  e.out = x & y;
      4'd1:  e.out = x | y;
      4'd2:  begin e.out = x + y; r = sx + sy; e.ovf = (r >= lim) || (r < -lim); end
      4'd3:  e.out = (x < y) ? W'(1) : W'(0);
      4'd4:  e.out = y << sh;
      4'd5:  e.out = y >> sh;
      4'd6:  begin e.out = x - y; r = sx - sy; e.ovf = (r >= lim) || (r < -lim); end
      4'd7:  e.out = (sx < sy) ? W'(1) : W'(0);
      4'd8:  e.out = W'($signed(y) >>> sh);
      4'd9:  e.out = h;
      4'd10: e.out = l;
      4'd12: e.out = ~(x | y);
      4'd13: e.out = x ^ y;
      default: e.out = '0;
    endcase
    e.zero = (e.out == '0);
    return e;
  endfunction

  function automatic md_exp_t md_ref(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    md_exp_t e;
    logic [2*W-1:0] xe, ye, p;
    logic [W-1:0] min_v;
    min_v = '0;
    min_v[W-1] = 1'b1;
    if (op == MD_MULT || op == MD_MULTU) begin
      xe = (op == MD_MULT) ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
      ye = (op == MD_MULT) ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
      p  = xe * ye;
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else if (y == '0) begin
      e.lo = '1;
      e.hi = x;
    end else if (op == MD_DIV && x == min_v && y == '1) begin
      e.lo = min_v;
      e.hi = '0;
    end else if (op == MD_DIV) begin
      e.lo = W'($signed(x) / $signed(y));
      e.hi = W'($signed(x) % $signed(y));
    end else begin
      e.lo = x / y;
      e.hi = x % y;
    end
    return e;
  endfunction

  // Called at 1ns after a rising edge; holds the inputs for one cycle
  task automatic alu_check(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y, input logic [SW-1:0] sh);
    ctl = c; a = x; b = y; shamt = sh;
    alu_q.push_back(alu_ref(c, x, y, sh, m_hi, m_lo));
    alu_vld = 1'b1;
    @(posedge clk); #1;
    alu_vld = 1'b0;
  endtask

  // Issues an MDU op now (1ns after an edge) and returns inside its DONE cycle
  task automatic md_run(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input int poke);
    md_exp_t e;
    int k, busy_n, done_at;
    e = md_ref(op, x, y);
    md_q.push_back(e);
    md_op = op; a = x; b = y; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    k = 1; busy_n = 0; done_at = 0;
    while (done_at == 0 && k <= int'(W) + 4) begin
      a = $urandom; b = $urandom; md_op = 2'($urandom);
      if (md_busy) busy_n++;
      if (md_done) done_at = k;
      else begin
        if (k == 3) begin
          ctl = ALU_MFLO; #1; chk("mflo_during_run", 64'(out), 64'(m_lo));
          ctl = ALU_MFHI; #1; chk("mfhi_during_run", 64'(out), 64'(m_hi));
        end
        md_start = (k == poke);
        @(posedge clk); #1;
        k++;
      end
    end
    md_start = 1'b0;
    chk("md_busy_cycles", 64'(busy_n), 64'(W));
    chk("md_done_cycle", 64'(done_at), 64'(W + 1));
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result
  initial begin
    alu_exp_t ea;
    md_exp_t  em;
    forever begin
      @(negedge clk);
      if (alu_vld) begin
        if (alu_q.size() == 0) chk("alu_unexpected", 64'(1), 64'(0));
        else begin
          ea = alu_q.pop_front();
          chk("alu_out", 64'(out), 64'(ea.out));
          chk("alu_zero", 64'(zero), 64'(ea.zero));
          chk("alu_overflow", 64'(overflow), 64'(ea.ovf));
        end
      end
      if (md_done) begin
        if (md_q.size() == 0) chk("md_unexpected_done", 64'(1), 64'(0));
        else begin
          em = md_q.pop_front();
          chk("md_hi", 64'(hi), 64'(em.hi));
          chk("md_lo", 64'(lo), 64'(em.lo));
        end
      end
    end
  end

  initial begin
    logic [1:0]   op;
    logic [W-1:0] x, y;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(md_busy), 64'(0));
    chk("reset_done", 64'(md_done), 64'(0));
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    alu_check(ALU_ADD, 32'h7FFF_FFFF, 32'h1, '0);
    alu_check(ALU_SUB, 32'h5, 32'h5, '0);
    alu_check(ALU_SUB, 32'h8000_0000, 32'h1, '0);
    alu_check(ALU_SLT, 32'h8000_0000, 32'h1, '0);
    alu_check(ALU_SLTU, 32'h8000_0000, 32'h1, '0);
    alu_check(ALU_SRA, $urandom, 32'h8000_0000, SW'(4));
    alu_check(ALU_SRL, $urandom, 32'h8000_0000, SW'(4));
    alu_check(4'd11, $urandom, $urandom, SW'($urandom));
    alu_check(ALU_ADD, 32'h8000_0000, 32'h8000_0000, '0);
    alu_check(ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, '0);

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? x : $urandom;
      alu_check(4'($urandom), x, y, SW'($urandom));
    end

    md_run(MD_MULT, 32'hFFFF_FFFD, 32'h7, 0);
    @(posedge clk); #1;
    md_run(MD_MULTU, 32'hFFFF_FFFD, 32'h7, 0);
    @(posedge clk); #1;
    md_run(MD_DIV, 32'hFFFF_FFF9, 32'h2, 0);
    @(posedge clk); #1;
    md_run(MD_DIVU, 32'd100, 32'h0, 0);
    @(posedge clk); #1;
    md_run(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    @(posedge clk); #1;
    md_run(MD_DIV, 32'hFFFF_FFF9, 32'h0, 0);
    @(posedge clk); #1;
    md_run(MD_MULTU, 32'd3, 32'd4, 5);
    md_run(MD_DIVU, 32'd9, 32'd2, 0);
    @(posedge clk); #1;
    alu_check(ALU_MFLO, $urandom, $urandom, '0);
    alu_check(ALU_MFHI, $urandom, $urandom, '0);

    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom);
      x  = $urandom;
      y  = ($urandom_range(0, 3) == 0) ? '0 : (($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 300)) : $urandom);
      md_run(op, x, y, $urandom_range(0, 1) == 0 ? 0 : $urandom_range(2, 20));
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;

    md_op = MD_MULT; a = 32'd5; b = 32'd7; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(md_busy), 64'(0));
    chk("async_rst_done", 64'(md_done), 64'(0));
    chk("async_rst_hi", 64'(hi), 64'(0));
    chk("async_rst_lo", 64'(lo), 64'(0));
    m_hi = '0;
    m_lo = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    md_run(MD_MULT, 32'd2, 32'd3, 0);
    @(posedge clk); #1;
    alu_check(ALU_MFLO, '0, '0, '0);

    repeat (3) @(posedge clk);
    #1;
    chk("alu_queue_drained", 64'(alu_q.size()), 64'(0));
    chk("md_queue_drained", 64'(md_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised successor to the single-cycle datapath ALU. It keeps a combinational ALU path for single-cycle ops, with correct signed and unsigned compares, shifts and an overflow flag. It adds an iterative multiply/divide unit (MDU) with architectural HI/LO registers and a start/busy/done handshake. It sits in the EX stage: the combinational result feeds the EX/MEM register, and the control unit stalls on md_busy.

Parameters:
W, 32, datapath width in bits (>= 4, power of two)
SW, $clog2(W), localparam, shift-amount width
CW, $clog2(W+1), localparam, iteration counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
ctl  in  4  combinational ALU op select
a  in  W  operand A (rs)
b  in  W  operand B (rt / immediate)
shamt  in  SW  shift amount
out  out  W  combinational result
zero  out  1  out == 0
overflow  out  1  signed overflow for add/sub
md_start  in  1  start MDU op, sampled on clk
md_op  in  2  00 mult, 01 multu, 10 div, 11 divu
md_busy  out  1  MDU iterating
md_done  out  1  one-cycle pulse; hi/lo valid
hi  out  W  HI register
lo  out  W  LO register

Behaviour:
- Combinational path (no latency), ctl codes:
  - 0 and, 1 or, 2 add, 3 sltu, 4 sll (b<<shamt), 5 srl, 6 sub, 7 slt (signed), 8 sra, 9 mfhi (out=hi), 10 mflo (out=lo), 12 nor, 13 xor.
  - Any other code: out = 0.
- Flags:
  - zero = (out == 0) for every code.
  - overflow: ctl=2 → a,b same sign and sum sign differs from a. ctl=6 → a,b signs differ and difference sign differs from a. Otherwise 0.
- slt = true signed a<b, using the sub result sign XOR sub overflow. sltu = unsigned borrow. Result zero-extended to W.
- Arithmetic is modulo 2^W; no exceptions raised.
- MDU FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with md_start=1: latch a, b, md_op, load counter = W, go to RUN.
  - RUN: one radix-2 step per cycle (shift-add multiply; restoring divide on magnitudes), counter decrements. At counter==1, go to DONE.
  - DONE: hi/lo are written on the edge that enters DONE; md_done=1 for exactly this cycle. Go to IDLE, or RUN if md_start=1.
- Timing: start sampled at edge 0 → md_busy high cycles 1..W; md_done and new hi/lo visible in cycle W+1. Back-to-back ops: start asserted in the DONE cycle is accepted.
- md_busy = (state==RUN). md_start while RUN is ignored. a/b/md_op changes during RUN have no effect.
- Signed mult/div:
  - Operate on magnitudes; the final negate is applied in the DONE write.
  - Product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- Multiply result: hi = product[2W-1:W], lo = product[W-1:0].
- Divide result: lo = quotient, hi = remainder.
- Divide by zero (both variants): full latency; lo = all ones, hi = a.
- Signed overflow (div, a = MIN, b = -1): lo = MIN, hi = 0.
- mfhi/mflo during RUN return the previous hi/lo. The control unit must stall on md_busy.
- Reset (async, any state, mid-operation included): state = IDLE, counter = 0, hi = lo = 0, md_busy = 0, md_done = 0, latched operands = 0. Any in-flight op is discarded.

Decomposition:
- alu_pkg: ALU ctl code localparams (ALU_AND..ALU_XOR, ALU_MFHI, ALU_MFLO); MD_MULT/MD_MULTU/MD_DIV/MD_DIVU; MDU state encoding.
- One sub-module: mdu_iter (FSM, counter, operand/accumulator registers, hi/lo, sign fix-up). alu_mdu holds the combinational ALU and instantiates mdu_iter.

Test Plan:
1. ctl=2, a=0x7FFFFFFF, b=1 → out=0x80000000, overflow=1, zero=0. ctl=6, a=b=5 → out=0, zero=1, overflow=0. ctl=6, a=0x80000000, b=1 → overflow=1.
2. a=0x80000000, b=1: ctl=7 → out=1; ctl=3 → out=0. ctl=8, a=x, b=0x80000000, shamt=4 → 0xF8000000; ctl=5, same inputs → 0x08000000. ctl=11 → out=0, zero=1.
3. mult a=0xFFFFFFFD, b=7 → busy cycles 1..32, done in cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB. multu, same operands → hi=0x00000006, lo=0xFFFFFFEB.
4. div a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=100, b=0 → lo=0xFFFFFFFF, hi=100. div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
5. multu 3×4 started; md_start with new operands in cycle 5 → ignored, result hi=0, lo=12. Start divu 9/2 in the DONE cycle → busy next cycle, lo=4, hi=1 after 33 more cycles. ctl=10 during RUN → old lo.
6. Assert rst asynchronously mid-RUN (cycle 10) → busy, done, hi, lo = 0 without a clock edge. After release, mult 2×3 → lo=6, hi=0 with normal latency.
